// File: rtl/conv_pool_pkg.sv
// Shared types and size helpers for the conv_pool scheduler and its tag pipe.
package conv_pool_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} sched_state_t;

  typedef struct packed {
    logic        v;
    logic [15:0] idx;
  } tag_t;

  // Number of stride-2 4x4 windows along one image dimension.
  function automatic int unsigned ow_f(input int unsigned img);
    return (img - 2) / 2;
  endfunction

  function automatic int unsigned oh_f(input int unsigned img);
    return (img - 2) / 2;
  endfunction

endpackage

// File: rtl/conv_pool_tag_pipe.sv
// Fixed-latency shift register that follows each window index through the conv_pool
// datapath so the result can be tagged with its output address at the tail.
module conv_pool_tag_pipe
  import conv_pool_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] idx,
  output tag_t        tail,
  output logic        empty
);

  tag_t stage_q [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= '{v: push, idx: idx};
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail = stage_q[PIPE_LAT-1];

  // Empty means nothing is pending behind the tail, so the tail is the final result.
  always_comb begin
    empty = ~push;
    for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
      if (stage_q[i].v) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_pool_sched.sv
// Window sequencer for conv_pool: fetches each packed 4x4 window, feeds the datapath and
// issues a write strobe with a raster output address for every pooled result.
module conv_pool_sched
  import conv_pool_pkg::*;
#(
  parameter int unsigned IMG_W    = 16,
  parameter int unsigned IMG_H    = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [1:0]        cfg_shift,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  output logic              dp_re,
  output logic [15:0]       dp_addr,
  output logic [1:0]        dp_shift,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OW = ow_f(IMG_W);
  localparam int unsigned OH = oh_f(IMG_H);

  sched_state_t      state_q, state_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       k_q, k_d;
  logic [15:0]       dp_addr_q, dp_addr_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [1:0]        shift_q, shift_d;
  logic              push;
  logic              last_win;
  logic              pipe_empty;
  tag_t              tail;

  assign last_win = (row_q == 16'(OH - 1)) && (col_q == 16'(OW - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    shift_d    = shift_q;
    push       = 1'b0;
    rd_req     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          in_base_d  = in_base;
          out_base_d = out_base;
          shift_d    = cfg_shift;
          row_d      = '0;
          col_d      = '0;
          k_d        = '0;
        end
      end
      REQ: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        // A same-cycle rd_valid is deliberately ignored here; data must follow the grant.
        if (rd_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (rd_valid) begin
          push = 1'b1;
          if (last_win) begin
            state_d = DRAIN;
          end else begin
            state_d = REQ;
            k_d     = k_q + 16'd1;
            if (col_q == 16'(OW - 1)) begin
              col_d = '0;
              row_d = row_q + 16'd1;
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp_addr_d = push ? k_q : dp_addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      dp_addr_q  <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      dp_addr_q  <= dp_addr_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      shift_q    <= shift_d;
    end
  end

  conv_pool_tag_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .idx  (k_q),
    .tail (tail),
    .empty(pipe_empty)
  );

  assign dp_re    = push;
  assign dp_addr  = dp_addr_d;
  assign dp_shift = shift_q;
  assign rd_addr  = in_base_q + ADDR_W'(k_q);
  assign out_we   = tail.v;
  assign out_addr = out_base_q + ADDR_W'(tail.idx);

endmodule

// File: tb/tb_conv_pool_sched.sv
// Bench for conv_pool_sched: a 6x6/PIPE_LAT=2 and a 16x16/PIPE_LAT=3 instance driven by a
// transaction-level memory model and a scoreboard of expected reads, writes and done.
module tb_conv_pool_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       start_v, rd_gnt_v, rd_valid_v, rd_req_v, dp_re_v, out_we_v, busy_v, done_v;
  logic [1:0][15:0] in_base_v, out_base_v, rd_addr_v, dp_addr_v, out_addr_v;
  logic [1:0][1:0]  cfg_shift_v, dp_shift_v;

  int checks   = 0;
  int failures = 0;

  conv_pool_sched #(
    .IMG_W(6), .IMG_H(6), .ADDR_W(16), .PIPE_LAT(2)
  ) u_small (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_base(in_base_v[0]),
    .out_base(out_base_v[0]), .cfg_shift(cfg_shift_v[0]), .rd_req(rd_req_v[0]),
    .rd_addr(rd_addr_v[0]), .rd_gnt(rd_gnt_v[0]), .rd_valid(rd_valid_v[0]),
    .dp_re(dp_re_v[0]), .dp_addr(dp_addr_v[0]), .dp_shift(dp_shift_v[0]),
    .out_we(out_we_v[0]), .out_addr(out_addr_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  conv_pool_sched #(
    .IMG_W(16), .IMG_H(16), .ADDR_W(16), .PIPE_LAT(3)
  ) u_big (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_base(in_base_v[1]),
    .out_base(out_base_v[1]), .cfg_shift(cfg_shift_v[1]), .rd_req(rd_req_v[1]),
    .rd_addr(rd_addr_v[1]), .rd_gnt(rd_gnt_v[1]), .rd_valid(rd_valid_v[1]),
    .dp_re(dp_re_v[1]), .dp_addr(dp_addr_v[1]), .dp_shift(dp_shift_v[1]),
    .out_we(out_we_v[1]), .out_addr(out_addr_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
  } wr_t;

  typedef struct {
    int          sel;
    logic [15:0] ib, ob;
    logic [1:0]  sh;
    int          gd, vd;
    bit          rnd, spur;
    int          restart_k, abort_k;
    bit          sod;
    int          e_rd;
    logic [15:0] e_fra, e_lra;
    int          e_wr;
    logic [15:0] e_fwa, e_lwa;
    bit          e_done;
  } vec_t;

  function automatic int nwin_f(input int sel);
    return (sel == 0) ? 4 : 49;
  endfunction

  function automatic int lat_f(input int sel);
    return (sel == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int sel, input string tag);
    chk({tag, "_rd_req"},   32'(rd_req_v[sel]),   0);
    chk({tag, "_rd_addr"},  32'(rd_addr_v[sel]),  0);
    chk({tag, "_dp_re"},    32'(dp_re_v[sel]),    0);
    chk({tag, "_dp_addr"},  32'(dp_addr_v[sel]),  0);
    chk({tag, "_dp_shift"}, 32'(dp_shift_v[sel]), 0);
    chk({tag, "_out_we"},   32'(out_we_v[sel]),   0);
    chk({tag, "_out_addr"}, 32'(out_addr_v[sel]), 0);
    chk({tag, "_busy"},     32'(busy_v[sel]),     0);
    chk({tag, "_done"},     32'(done_v[sel]),     0);
  endtask

  // Plays memory for one frame and scores every cycle against the window-level model.
  task automatic run_frame(input int sel, input logic [15:0] ib, input logic [15:0] ob,
                           input logic [1:0] sh, input int gd, input int vd,
                           input bit rnd, input bit spur, input int restart_k,
                           input int abort_k, input bit sod,
                           output int n_rd, output int n_wr,
                           output logic [15:0] f_ra, output logic [15:0] l_ra,
                           output logic [15:0] f_wa, output logic [15:0] l_wa,
                           output bit saw_done);
    int  cyc, last_we, gcnt, vcnt, mst, nk, nw, lt, rk;
    bit  running, fin, exp_valid, exp_done, exp_we, gnt_now, aborted;
    wr_t wq[$];
    cyc = 0; last_we = -10; mst = 0; nk = 0; rk = restart_k;
    nw = nwin_f(sel); lt = lat_f(sel);
    running = 0; fin = 0; aborted = 0;
    n_rd = 0; n_wr = 0; f_ra = '0; l_ra = '0; f_wa = '0; l_wa = '0; saw_done = 0;

    @(posedge clk); #1;
    in_base_v[sel] = ib; out_base_v[sel] = ob; cfg_shift_v[sel] = sh; start_v[sel] = 1'b1;
    rd_valid_v[sel] = spur;
    @(negedge clk);
    chk("dp_re_idle", 32'(dp_re_v[sel]), 0);
    chk("busy_idle", 32'(busy_v[sel]), 0);
    gcnt = rnd ? int'($urandom_range(0, 3)) : gd;
    vcnt = 0;
    running = 1;

    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start_v[sel] = 1'b0; in_base_v[sel] = ~ib; out_base_v[sel] = ob ^ 16'h5a5a;
      cfg_shift_v[sel] = ~sh; rd_gnt_v[sel] = 1'b0; rd_valid_v[sel] = 1'b0;
      exp_valid = 0;
      exp_done = (n_wr == nw) && (cyc == last_we + 1);
      if (abort_k >= 0 && nk == abort_k && mst == 1) begin
        rst = 1'b0;
        aborted = 1;
      end else if (mst == 0) begin
        if (rd_req_v[sel]) begin
          if (rk >= 0 && nk == rk) begin
            start_v[sel] = 1'b1; in_base_v[sel] = ib + 16'h0777; out_base_v[sel] = ob + 16'h0999;
            rk = -1;
          end
          if (gcnt == 0) begin
            rd_gnt_v[sel] = 1'b1;
            mst = 1;
            vcnt = rnd ? int'($urandom_range(1, 3)) : vd;
            if (n_rd == 0) f_ra = rd_addr_v[sel];
            l_ra = rd_addr_v[sel];
            n_rd++;
          end else begin
            gcnt--;
          end
        end
      end else begin
        vcnt--;
        if (vcnt == 0) begin
          rd_valid_v[sel] = 1'b1;
          exp_valid = 1;
          mst = 0;
          gcnt = rnd ? int'($urandom_range(0, 3)) : gd;
        end
      end
      gnt_now = rd_gnt_v[sel];
      // Stray data, including data coincident with a grant, must never reach the datapath.
      if (spur && !exp_valid && !aborted && (mst == 0 || gnt_now) && $urandom_range(0, 2) == 0)
        rd_valid_v[sel] = 1'b1;
      if (exp_done && sod) begin
        start_v[sel] = 1'b1; in_base_v[sel] = ib + 16'h0001; out_base_v[sel] = ob + 16'h0001;
      end

      @(negedge clk);
      chk("dp_re", 32'(dp_re_v[sel]), 32'(exp_valid));
      if (rd_req_v[sel]) chk("rd_addr", 32'(rd_addr_v[sel]), 32'(16'(ib + nk)));
      if (mst == 1 && !gnt_now) chk("rd_req_outstanding", 32'(rd_req_v[sel]), 0);
      if (exp_valid) begin
        chk("dp_addr", 32'(dp_addr_v[sel]), 32'(nk));
        wq.push_back('{due: cyc + lt, addr: 16'(ob + nk)});
        nk++;
      end
      exp_we = (wq.size() > 0) && (wq[0].due == cyc);
      chk("out_we", 32'(out_we_v[sel]), 32'(exp_we));
      if (exp_we) begin
        chk("out_addr", 32'(out_addr_v[sel]), 32'(wq[0].addr));
        if (n_wr == 0) f_wa = out_addr_v[sel];
        l_wa = out_addr_v[sel];
        void'(wq.pop_front());
        n_wr++;
        last_we = cyc;
      end
      chk("done", 32'(done_v[sel]), 32'(exp_done));
      chk("busy", 32'(busy_v[sel]), 32'(running && !exp_done));
      chk("dp_shift", 32'(dp_shift_v[sel]), 32'(sh));
      if (done_v[sel]) saw_done = 1;
      if (exp_done) begin
        running = 0;
        fin = 1;
      end
      if (aborted) begin
        @(posedge clk); #1;
        rst = 1'b1; rd_valid_v[sel] = 1'b0; rd_gnt_v[sel] = 1'b0;
        @(negedge clk);
        chk_zero(sel, "abort");
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("abort_out_we", 32'(out_we_v[sel]), 0);
          chk("abort_done", 32'(done_v[sel]), 0);
          if (done_v[sel]) saw_done = 1;
        end
        fin = 1;
      end
      if (!fin && cyc > 5000) begin
        checks++;
        failures++;
        $display("FAIL frame_timeout actual=%0d_writes required=%0d_writes", n_wr, nw);
        fin = 1;
      end
    end

    if (sod) begin
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      @(negedge clk);
      chk("start_on_done_busy", 32'(busy_v[sel]), 0);
      chk("start_on_done_rd_req", 32'(rd_req_v[sel]), 0);
    end
    @(posedge clk); #1;
    start_v[sel] = 1'b0; rd_gnt_v[sel] = 1'b0; rd_valid_v[sel] = 1'b0;
    in_base_v[sel] = '0; out_base_v[sel] = '0; cfg_shift_v[sel] = '0;
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          n_rd, n_wr, sel, nw;
    logic [15:0] f_ra, l_ra, f_wa, l_wa, ib, ob;
    logic [1:0]  sh;
    bit          saw_done;

    //            sel ib        ob        sh    gd vd rnd   spur  rk  ak  sod
    //            e_rd e_fra     e_lra     e_wr e_fwa     e_lwa     e_done
    vecs[0] = '{0, 16'h0100, 16'h0200, 2'd1, 1, 1, 1'b0, 1'b0, -1, -1, 1'b0,
                4,  16'h0100, 16'h0103, 4,  16'h0200, 16'h0203, 1'b1};
    vecs[1] = '{0, 16'h0010, 16'h0020, 2'd2, 5, 1, 1'b0, 1'b0, -1, -1, 1'b0,
                4,  16'h0010, 16'h0013, 4,  16'h0020, 16'h0023, 1'b1};
    vecs[2] = '{0, 16'h0300, 16'h0400, 2'd3, 0, 2, 1'b1, 1'b1, -1, -1, 1'b0,
                4,  16'h0300, 16'h0303, 4,  16'h0400, 16'h0403, 1'b1};
    vecs[3] = '{1, 16'h1000, 16'h2000, 2'd0, 1, 1, 1'b0, 1'b0,  5, -1, 1'b0,
                49, 16'h1000, 16'h1030, 49, 16'h2000, 16'h2030, 1'b1};
    vecs[4] = '{1, 16'h0040, 16'h0800, 2'd1, 1, 1, 1'b0, 1'b0, -1,  2, 1'b0,
                3,  16'h0040, 16'h0042, 2,  16'h0800, 16'h0801, 1'b0};
    vecs[5] = '{1, 16'hFFF0, 16'hFFE0, 2'd2, 0, 1, 1'b1, 1'b1, -1, -1, 1'b1,
                49, 16'hFFF0, 16'h0020, 49, 16'hFFE0, 16'h0010, 1'b1};
    vecs[6] = '{0, 16'h00AA, 16'h00BB, 2'd3, 0, 1, 1'b0, 1'b1, -1, -1, 1'b1,
                4,  16'h00AA, 16'h00AD, 4,  16'h00BB, 16'h00BE, 1'b1};

    start_v = '0; rd_gnt_v = '0; rd_valid_v = '0;
    in_base_v = '0; out_base_v = '0; cfg_shift_v = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset_small");
    chk_zero(1, "reset_big");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].sel, vecs[v].ib, vecs[v].ob, vecs[v].sh, vecs[v].gd, vecs[v].vd,
                vecs[v].rnd, vecs[v].spur, vecs[v].restart_k, vecs[v].abort_k, vecs[v].sod,
                n_rd, n_wr, f_ra, l_ra, f_wa, l_wa, saw_done);
      chk($sformatf("v%0d_n_rd", v), 32'(n_rd), 32'(vecs[v].e_rd));
      chk($sformatf("v%0d_first_rd", v), 32'(f_ra), 32'(vecs[v].e_fra));
      chk($sformatf("v%0d_last_rd", v), 32'(l_ra), 32'(vecs[v].e_lra));
      chk($sformatf("v%0d_n_wr", v), 32'(n_wr), 32'(vecs[v].e_wr));
      chk($sformatf("v%0d_first_wr", v), 32'(f_wa), 32'(vecs[v].e_fwa));
      chk($sformatf("v%0d_last_wr", v), 32'(l_wa), 32'(vecs[v].e_lwa));
      chk($sformatf("v%0d_done_seen", v), 32'(saw_done), 32'(vecs[v].e_done));
    end

    for (int r = 0; r < 4; r++) begin
      sel = int'($urandom_range(0, 1));
      ib  = 16'($urandom);
      ob  = 16'($urandom);
      sh  = 2'($urandom);
      nw  = nwin_f(sel);
      run_frame(sel, ib, ob, sh, 0, 1, 1'b1, 1'b1, -1, -1, 1'b0,
                n_rd, n_wr, f_ra, l_ra, f_wa, l_wa, saw_done);
      chk($sformatf("r%0d_n_rd", r), 32'(n_rd), 32'(nw));
      chk($sformatf("r%0d_last_rd", r), 32'(l_ra), 32'(16'(ib + nw - 1)));
      chk($sformatf("r%0d_n_wr", r), 32'(n_wr), 32'(nw));
      chk($sformatf("r%0d_first_wr", r), 32'(f_wa), 32'(ob));
      chk($sformatf("r%0d_last_wr", r), 32'(l_wa), 32'(16'(ob + nw - 1)));
      chk($sformatf("r%0d_done_seen", r), 32'(saw_done), 1);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
